// File: rtl/time_set_controller.sv
// Time-of-day controller: HH:MM:SS counters plus a RUN/SET_H/SET_M/SET_S mode FSM
// that shares a single increment button between the three fields.
module time_set_controller #(
    parameter int HOUR_MOD = 24,
    parameter int MIN_MOD  = 60
) (
    input  logic       mainClk,
    input  logic       rstN,
    input  logic       tickSec,
    input  logic       btnMode,
    input  logic       btnInc,
    output logic [5:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       blink,
    output logic       dayPulse
);
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10,
        SET_S = 2'b11
    } mode_t;

    localparam logic [5:0] HOUR_LAST = 6'(HOUR_MOD - 1);
    localparam logic [5:0] MIN_LAST  = 6'(MIN_MOD - 1);

    mode_t      state_q, state_d;
    logic [5:0] hours_d, minutes_d, seconds_d;
    logic       blink_d, day_pulse_d;
    logic [2:0] mode_sync, inc_sync;
    logic       mode_edge, inc_edge;
    logic       sec_wrap, min_wrap, hour_wrap;

    // Three flops per button: two to synchronise, the third only to spot the rising edge.
    always_ff @(posedge mainClk or negedge rstN) begin
        if (!rstN) begin
            mode_sync <= '0;
            inc_sync  <= '0;
        end else begin
            mode_sync <= {mode_sync[1:0], btnMode};
            inc_sync  <= {inc_sync[1:0], btnInc};
        end
    end

    assign mode_edge = mode_sync[1] & ~mode_sync[2];
    assign inc_edge  = inc_sync[1] & ~inc_sync[2];

    assign sec_wrap  = (seconds == MIN_LAST);
    assign min_wrap  = (minutes == MIN_LAST);
    assign hour_wrap = (hours == HOUR_LAST);

    always_ff @(posedge mainClk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= RUN;
            hours    <= '0;
            minutes  <= '0;
            seconds  <= '0;
            blink    <= 1'b0;
            dayPulse <= 1'b0;
        end else begin
            state_q  <= state_d;
            hours    <= hours_d;
            minutes  <= minutes_d;
            seconds  <= seconds_d;
            blink    <= blink_d;
            dayPulse <= day_pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hours_d     = hours;
        minutes_d   = minutes;
        seconds_d   = seconds;
        blink_d     = blink;
        day_pulse_d = 1'b0;
        case (state_q)
            RUN: begin
                blink_d = 1'b0;
                if (tickSec) begin
                    seconds_d = sec_wrap ? 6'd0 : seconds + 6'd1;
                    if (sec_wrap) begin
                        minutes_d = min_wrap ? 6'd0 : minutes + 6'd1;
                        if (min_wrap) begin
                            hours_d     = hour_wrap ? 6'd0 : hours + 6'd1;
                            day_pulse_d = hour_wrap;
                        end
                    end
                end
                // A tick in the same cycle still lands before we leave RUN.
                if (mode_edge) begin
                    state_d = SET_H;
                    blink_d = 1'b1;
                end
            end
            default: begin
                if (mode_edge) begin
                    state_d = (state_q == SET_S) ? RUN : mode_t'(state_q + 2'd1);
                    blink_d = (state_q != SET_S);
                end else begin
                    if (tickSec) begin
                        blink_d = ~blink;
                    end
                    if (inc_edge) begin
                        case (state_q)
                            SET_H:   hours_d   = hour_wrap ? 6'd0 : hours + 6'd1;
                            SET_M:   minutes_d = min_wrap ? 6'd0 : minutes + 6'd1;
                            default: seconds_d = sec_wrap ? 6'd0 : seconds + 6'd1;
                        endcase
                    end
                end
            end
        endcase
    end

    assign mode = state_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller: directed scenarios plus random stimulus,
// all compared against a time-of-day reference model.
module tb_time_set_controller;
    logic       mainClk = 1'b0;
    logic       rstN    = 1'b1;
    logic       tickSec = 1'b0;
    logic       btnMode = 1'b0;
    logic       btnInc  = 1'b0;
    logic [5:0] hours, minutes, seconds;
    logic [1:0] mode;
    logic       blink, dayPulse;

    int checkCount = 0;
    int passCount  = 0;

    int mH, mM, mS, mMode;
    bit mBlink, mDay;
    bit modeHist[4];
    bit incHist[4];

    time_set_controller #(.HOUR_MOD(24), .MIN_MOD(60)) dut (
        .mainClk (mainClk),
        .rstN    (rstN),
        .tickSec (tickSec),
        .btnMode (btnMode),
        .btnInc  (btnInc),
        .hours   (hours),
        .minutes (minutes),
        .seconds (seconds),
        .mode    (mode),
        .blink   (blink),
        .dayPulse(dayPulse)
    );

    always #5 mainClk = ~mainClk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
        checkCount++;
        if (observed === 32'(expected)) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    task automatic modelReset();
        mH = 0; mM = 0; mS = 0; mMode = 0; mBlink = 0; mDay = 0;
        for (int i = 0; i < 4; i++) begin
            modeHist[i] = 0;
            incHist[i]  = 0;
        end
    endtask

    // A press acts two edges after it is first sampled high, if the sample before was low.
    task automatic modelStep(input bit tick, input bit bm, input bit bi);
        bit me, ie;
        int total;
        for (int i = 3; i > 0; i--) begin
            modeHist[i] = modeHist[i-1];
            incHist[i]  = incHist[i-1];
        end
        modeHist[0] = bm;
        incHist[0]  = bi;
        me = modeHist[2] && !modeHist[3];
        ie = incHist[2] && !incHist[3];
        mDay = 0;
        if (mMode == 0) begin
            if (tick) begin
                total = (mH * 60 + mM) * 60 + mS + 1;
                if (total == 24 * 3600) begin
                    total = 0;
                    mDay  = 1;
                end
                mH = total / 3600;
                mM = (total / 60) % 60;
                mS = total % 60;
            end
            mBlink = me;
            if (me) mMode = 1;
        end else if (me) begin
            mMode  = (mMode + 1) % 4;
            mBlink = (mMode != 0);
        end else begin
            if (tick) mBlink = !mBlink;
            if (ie) begin
                case (mMode)
                    1:       mH = (mH + 1) % 24;
                    2:       mM = (mM + 1) % 60;
                    default: mS = (mS + 1) % 60;
                endcase
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("hours", 32'(hours), mH);
        checkOutput("minutes", 32'(minutes), mM);
        checkOutput("seconds", 32'(seconds), mS);
        checkOutput("mode", 32'(mode), mMode);
        checkOutput("blink", 32'(blink), int'(mBlink));
        checkOutput("dayPulse", 32'(dayPulse), int'(mDay));
    endtask

    task automatic applyStimulus(input bit tick, input bit bm, input bit bi);
        tickSec = tick;
        btnMode = bm;
        btnInc  = bi;
        @(posedge mainClk);
        #1;
        modelStep(tick, bm, bi);
        compareAll();
    endtask

    task automatic pressButton(input bit bm, input bit bi);
        applyStimulus(0, bm, bi);
        applyStimulus(0, bm, bi);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
    endtask

    task automatic pressInc(input int n);
        for (int i = 0; i < n; i++) pressButton(0, 1);
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for an edge.
    task automatic doReset();
        tickSec = 0; btnMode = 0; btnInc = 0;
        #3 rstN = 1'b0;
        #1;
        checkOutput("rstHours", 32'(hours), 0);
        checkOutput("rstMinutes", 32'(minutes), 0);
        checkOutput("rstSeconds", 32'(seconds), 0);
        checkOutput("rstMode", 32'(mode), 0);
        checkOutput("rstBlink", 32'(blink), 0);
        checkOutput("rstDayPulse", 32'(dayPulse), 0);
        modelReset();
        @(posedge mainClk);
        #2 rstN = 1'b1;
    endtask

    task automatic setTime(input int h, input int m, input int s);
        pressButton(1, 0);
        pressInc(h);
        pressButton(1, 0);
        pressInc(m);
        pressButton(1, 0);
        pressInc(s);
        pressButton(1, 0);
    endtask

    initial begin
        modelReset();
        #1 rstN = 1'b0;
        #11 rstN = 1'b1;
        checkOutput("initMode", 32'(mode), 0);
        checkOutput("initHours", 32'(hours), 0);

        // Reset in the middle of normal operation.
        setTime(12, 34, 56);
        checkOutput("set12", 32'(hours), 12);
        checkOutput("set34", 32'(minutes), 34);
        checkOutput("set56", 32'(seconds), 56);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0);
        doReset();
        applyStimulus(0, 0, 0);
        checkOutput("postRstMode", 32'(mode), 0);

        // Day rollover, then inc in RUN must be ignored.
        setTime(23, 59, 59);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("rollHours", 32'(hours), 0);
        checkOutput("rollSeconds", 32'(seconds), 0);
        checkOutput("rollDay", 32'(dayPulse), 1);
        applyStimulus(0, 0, 0);
        checkOutput("rollDayOnce", 32'(dayPulse), 0);
        pressInc(1);
        checkOutput("runIncIgnored", 32'(seconds), 0);

        // Set sequence with minute wrap and no carry into hours.
        doReset();
        pressButton(1, 0);
        pressInc(5);
        pressButton(1, 0);
        pressInc(61);
        pressButton(1, 0);
        pressInc(3);
        pressButton(1, 0);
        checkOutput("seqHours", 32'(hours), 5);
        checkOutput("seqMinutes", 32'(minutes), 1);
        checkOutput("seqSeconds", 32'(seconds), 3);
        checkOutput("seqMode", 32'(mode), 0);

        // Held inc in SET_H acts once, two edges after first sample.
        doReset();
        pressButton(1, 0);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(0, 0, 1);
            if (i < 3) checkOutput("holdTiming", 32'(hours), (i >= 2) ? 1 : 0);
        end
        applyStimulus(0, 0, 0);
        checkOutput("holdOnce", 32'(hours), 1);

        // Halt and blink in SET_M.
        pressButton(1, 0);
        checkOutput("enterSetM", 32'(blink), 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0);
            checkOutput("blinkSeq", 32'(blink), (i % 2 == 0) ? 0 : 1);
            checkOutput("haltSeconds", 32'(seconds), 0);
        end

        // Mode and inc edges aligned in SET_M.
        pressButton(1, 1);
        checkOutput("collideMode", 32'(mode), 3);
        checkOutput("collideMinutes", 32'(minutes), 0);

        // Random stimulus against the model.
        begin
            bit bm, bi;
            bm = 0; bi = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(15) == 0) bm = !bm;
                if ($urandom_range(3) == 0) bi = !bi;
                applyStimulus(($urandom_range(3) == 0), bm, bi);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
Mode/sequencing controller for the digital clock's time-of-day registers. It owns the hours/minutes/seconds counters and shares one increment button between the three fields under a mode FSM: RUN (normal timekeeping), SET_H, SET_M, SET_S. The block sits between the push-button debouncers/1 Hz enable divider and the display/BCD conversion logic. It replaces per-field ad-hoc adjust logic with one arbitrated controller.

Parameters:
HOUR_MOD, 24, hour field modulus (hours count 0..HOUR_MOD-1)
MIN_MOD, 60, minute and second field modulus

Ports:
mainClk  input  1  system clock; all state on rising edge
rstN  input  1  asynchronous, active-low reset
tickSec  input  1  one-cycle 1 Hz enable pulse, synchronous to mainClk
btnMode  input  1  debounced mode button level, asynchronous to mainClk
btnInc  input  1  debounced increment button level, asynchronous to mainClk
hours  output  6  current hours 0..HOUR_MOD-1
minutes  output  6  current minutes 0..MIN_MOD-1
seconds  output  6  current seconds 0..MIN_MOD-1
mode  output  2  00 RUN, 01 SET_H, 10 SET_M, 11 SET_S
blink  output  1  display blank/flash control for the selected field
dayPulse  output  1  one-cycle pulse on the RUN rollover 23:59:59 -> 00:00:00

Behaviour:
- Interface: one clock (mainClk). Reset is asynchronous and active-low (rstN).
- Reset (rstN=0, asynchronous): hours=minutes=seconds=0, mode=RUN(00), blink=0, dayPulse=0, all synchroniser/edge flops=0. On release, operation resumes at the next mainClk edge.
- Button input path: each button passes through 3 flops (s1, s2, s3). edge = s2 & ~s3. An input first sampled high at edge k causes its action at edge k+2. A held button produces exactly one action. The button must go low and then high again to act again.
- FSM: RUN -modeEdge-> SET_H -modeEdge-> SET_M -modeEdge-> SET_S -modeEdge-> RUN. No other transitions. mode output is the registered state.
- RUN:
  - On tickSec: seconds+1. At MIN_MOD-1, seconds wrap to 0 and carry to minutes. Minutes wrap at MIN_MOD-1 and carry to hours. Hours wrap at HOUR_MOD-1 to 0.
  - dayPulse=1 for the single cycle after the full 23:59:59 -> 00:00:00 wrap, 0 otherwise.
  - incEdge is ignored. blink=0.
- SET_x:
  - tickSec does not advance time. Timekeeping halts.
  - incEdge increments only the selected field, with wrap and no carry: hours 23->0, minutes 59->0, seconds 59->0.
  - blink toggles on every tickSec and is forced to 1 on entry into any SET state.
  - dayPulse=0.
- Exiting SET_S to RUN: fields keep their set values. Counting resumes at the next tickSec. No partial-second compensation.
- Simultaneous events:
  - modeEdge and incEdge in the same cycle: the mode change wins and the increment is dropped.
  - tickSec and modeEdge in the same cycle while in RUN: the tick is applied, then the state becomes SET_H.
  - tickSec in the same cycle as the SET_S->RUN transition: the tick is ignored.
- Width rules: fields are 6-bit unsigned. Compare-then-reset; never rely on overflow. Values ≥ the modulus are unreachable.
- Outputs are registered. Latency from tickSec to updated fields is 1 cycle.

Test Plan:
1. Reset mid-operation: load 12:34:56, assert rstN=0 between clock edges -> all outputs 0 immediately, without waiting for a clock edge; mode=00 after release.
2. Rollover: preset 23:59:59 in RUN, pulse tickSec -> next cycle 00:00:00, dayPulse=1 for exactly 1 cycle; pulse btnInc in RUN -> no change.
3. Set sequence: from 00:00:00, press mode once, inc ×5; mode, inc ×61; mode, inc ×3; mode -> reads 05:01:03, mode=00. The 61 presses wrap minutes through 0 and hours stay 5 (no carry).
4. Button timing: btnInc rises before edge k and is held 100 cycles in SET_H -> hours +1 exactly once, updated at edge k+2.
5. Collision: modeEdge and incEdge aligned in SET_M -> state SET_S, minutes unchanged.
6. Halt/blink: in SET_M apply 4 tickSec pulses -> seconds unchanged; blink sequence 1->0->1->0->1.
